// File: rtl/deserialize_pkg.sv
// Shared helpers for the tagged {index, data} argument stream produced by serialize.
package deserialize_pkg;

    // Width of the slot-index field in front of each data word; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned argn);
        return (argn < 2) ? 1 : $clog2(argn);
    endfunction

endpackage

// File: rtl/deserialize.sv
// Gathers one word per slot index from a tagged stream and emits the full argument vector,
// double-buffered so the next set collects while the previous result waits for res_rdy.
module deserialize
    import deserialize_pkg::*;
#(
    parameter int unsigned  ARGW = 16,
    parameter int unsigned  ARGN = 2,
    localparam int unsigned IDXW = idx_width(ARGN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_stb,
    input  logic [IDXW+ARGW-1:0] arg_dat,
    output logic                 arg_rdy,
    output logic                 res_stb,
    output logic [ARGN*ARGW-1:0] res_dat,
    input  logic                 res_rdy
);

    logic [IDXW-1:0]      idx;
    logic [ARGW-1:0]      wrd;
    logic [ARGN-1:0]      flg;
    logic [ARGN-1:0]      hit;
    logic [ARGN*ARGW-1:0] slot_vec;
    logic                 accept;
    logic                 xfer;

    assign idx = arg_dat[IDXW+ARGW-1:ARGW];
    assign wrd = arg_dat[ARGW-1:0];

    // An out-of-range index hits no slot, so it is always ready and simply dropped.
    assign arg_rdy = ~|(hit & flg);
    assign accept  = arg_stb & arg_rdy;
    assign xfer    = (&flg) & (~res_stb | res_rdy);

    for (genvar n = 0; n < ARGN; n++) begin : g_slot
        logic [ARGW-1:0] slot_q;
        logic            flg_q;

        assign hit[n] = (idx == IDXW'(n));

        // A full set blocks every in-range accept, so clear and fill never collide.
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q <= '0;
                flg_q  <= 1'b0;
            end else if (xfer) begin
                flg_q  <= 1'b0;
            end else if (accept && hit[n]) begin
                slot_q <= wrd;
                flg_q  <= 1'b1;
            end
        end

        assign flg[n]                    = flg_q;
        assign slot_vec[n*ARGW +: ARGW] = slot_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_stb <= 1'b0;
            res_dat <= '0;
        end else if (xfer) begin
            res_stb <= 1'b1;
            res_dat <= slot_vec;
        end else if (res_rdy) begin
            res_stb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserialize.sv
// Directed and randomized checks of deserialize at ARGN = 2, 3 and 4 against a
// set-level reference model.
module tb_deserialize;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        stb2, rr2, rdy2, rs2;
    logic [16:0] dat2;
    logic [31:0] rd2;
    logic        stb3, rr3, rdy3, rs3;
    logic [17:0] dat3;
    logic [47:0] rd3;
    logic        stb4, rr4, rdy4, rs4;
    logic [17:0] dat4;
    logic [127:0] rd4;

    deserialize #(.ARGW(16), .ARGN(2)) d2 (
        .clk(clk), .rst(rst), .arg_stb(stb2), .arg_dat(dat2), .arg_rdy(rdy2),
        .res_stb(rs2), .res_dat(rd2), .res_rdy(rr2)
    );
    deserialize #(.ARGW(16), .ARGN(3)) d3 (
        .clk(clk), .rst(rst), .arg_stb(stb3), .arg_dat(dat3), .arg_rdy(rdy3),
        .res_stb(rs3), .res_dat(rd3), .res_rdy(rr3)
    );
    deserialize #(.ARGW(16), .ARGN(4)) d4 (
        .clk(clk), .rst(rst), .arg_stb(stb4), .arg_dat(dat4), .arg_rdy(rdy4),
        .res_stb(rs4), .res_dat(rd4), .res_rdy(rr4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until the edge that accepts it.
    task automatic send2(input logic idx, input logic [15:0] d);
        int n;
        n    = 0;
        stb2 = 1'b1;
        dat2 = {idx, d};
        @(negedge clk);
        while (!rdy2 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send2_timeout", 128'(n >= 50), 128'(0));
        @(posedge clk);
        #1 stb2 = 1'b0;
    endtask

    task automatic send3(input logic [1:0] idx, input logic [15:0] d);
        int n;
        n    = 0;
        stb3 = 1'b1;
        dat3 = {idx, d};
        @(negedge clk);
        while (!rdy3 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send3_timeout", 128'(n >= 50), 128'(0));
        @(posedge clk);
        #1 stb3 = 1'b0;
    endtask

    logic [1:0]   sidx [400];
    logic [15:0]  sdat [400];
    logic [127:0] exp_q [$];
    logic [127:0] vec;
    logic [15:0]  w;
    int           perm [4];
    int           j, t, p, cyc;

    initial begin
        stb2 = 0; rr2 = 1; dat2 = '0;
        stb3 = 0; rr3 = 0; dat3 = '0;
        stb4 = 0; rr4 = 0; dat4 = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stb2", 128'(rs2), 0);
        check("rst_dat2", 128'(rd2), 0);
        check("rst_rdy2", 128'(rdy2), 1);
        check("rst_stb3", 128'(rs3), 0);
        check("rst_dat3", 128'(rd3), 0);
        check("rst_rdy3", 128'(rdy3), 1);

        // Basic collection, result one cycle after the completing accept
        @(posedge clk); #1;
        send2(1'b0, 16'h1111);
        send2(1'b1, 16'h2222);
        @(negedge clk);
        check("basic_latency_low", 128'(rs2), 0);
        @(negedge clk);
        check("basic_stb", 128'(rs2), 1);
        check("basic_dat", 128'(rd2), 128'h2222_1111);
        @(negedge clk);
        check("basic_drain", 128'(rs2), 0);

        // Reverse order
        @(posedge clk); #1;
        send2(1'b1, 16'hBEEF);
        send2(1'b0, 16'hCAFE);
        @(negedge clk);
        @(negedge clk);
        check("rev_stb", 128'(rs2), 1);
        check("rev_dat", 128'(rd2), 128'hBEEF_CAFE);

        // Duplicate index stalls until the set is transferred
        @(posedge clk); #1;
        send2(1'b0, 16'hAAAA);
        stb2 = 1'b1;
        dat2 = {1'b0, 16'hBBBB};
        @(negedge clk);
        check("dup_stall_a", 128'(rdy2), 0);
        @(negedge clk);
        check("dup_stall_b", 128'(rdy2), 0);
        @(posedge clk); #1;
        dat2 = {1'b1, 16'h5555};
        @(negedge clk);
        check("dup_fill_rdy", 128'(rdy2), 1);
        @(posedge clk); #1;
        dat2 = {1'b0, 16'hBBBB};
        @(negedge clk);
        check("dup_full_stall", 128'(rdy2), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("dup_res_stb", 128'(rs2), 1);
        check("dup_res_dat", 128'(rd2), 128'h5555_AAAA);
        check("dup_released", 128'(rdy2), 1);
        @(posedge clk); #1;
        stb2 = 1'b0;
        send2(1'b1, 16'h6666);
        @(negedge clk);
        @(negedge clk);
        check("dup_next_dat", 128'(rd2), 128'h6666_BBBB);

        // Back-pressure with ARGN = 3
        @(posedge clk); #1;
        rr3 = 1'b0;
        send3(2'd0, 16'hA000);
        send3(2'd1, 16'hA001);
        send3(2'd2, 16'hA002);
        send3(2'd0, 16'hB000);
        send3(2'd1, 16'hB001);
        send3(2'd2, 16'hB002);
        @(negedge clk);
        check("bp_stb", 128'(rs3), 1);
        check("bp_held", 128'(rd3), 128'hA002_A001_A000);
        @(posedge clk); #1;
        stb3 = 1'b1;
        dat3 = {2'd0, 16'hC0C0};
        @(negedge clk);
        check("bp_stall0", 128'(rdy3), 0);
        check("bp_held2", 128'(rd3), 128'hA002_A001_A000);
        dat3 = {2'd1, 16'hC1C1};
        #1 check("bp_stall1", 128'(rdy3), 0);
        @(posedge clk); #1;
        stb3 = 1'b0;
        rr3  = 1'b1;
        @(posedge clk); #1;
        rr3  = 1'b0;
        @(negedge clk);
        check("bp_second_stb", 128'(rs3), 1);
        check("bp_second_dat", 128'(rd3), 128'hB002_B001_B000);
        @(negedge clk);
        check("bp_second_hold", 128'(rd3), 128'hB002_B001_B000);

        // Out-of-range index is swallowed without side effects
        @(posedge clk); #1;
        rr3  = 1'b1;
        dat3 = {2'd3, 16'h1234};
        #1 check("oor_rdy", 128'(rdy3), 1);
        send3(2'd3, 16'h1234);
        dat3 = {2'd0, 16'h0000};
        #1 check("oor_no_flag", 128'(rdy3), 1);
        send3(2'd0, 16'hC000);
        send3(2'd1, 16'hC001);
        send3(2'd2, 16'hC002);
        @(negedge clk);
        @(negedge clk);
        check("oor_res_stb", 128'(rs3), 1);
        check("oor_res_dat", 128'(rd3), 128'hC002_C001_C000);

        // Mid-operation reset discards the partial set
        @(posedge clk); #1;
        send3(2'd0, 16'hD000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_stb", 128'(rs3), 0);
        check("mrst_dat", 128'(rd3), 0);
        @(posedge clk); #1;
        send3(2'd1, 16'hD001);
        send3(2'd2, 16'hD002);
        repeat (3) @(negedge clk);
        check("mrst_no_result", 128'(rs3), 0);
        @(posedge clk); #1;
        send3(2'd0, 16'hD003);
        @(negedge clk);
        @(negedge clk);
        check("mrst_res_stb", 128'(rs3), 1);
        check("mrst_res_dat", 128'(rd3), 128'hD002_D001_D003);

        // Streaming, ARGN = 4: 100 sets in shuffled slot order, random back-pressure
        for (int s = 0; s < 100; s++) begin
            for (int k = 0; k < 4; k++) perm[k] = k;
            for (int k = 3; k > 0; k--) begin
                j       = $urandom_range(0, k);
                t       = perm[k];
                perm[k] = perm[j];
                perm[j] = t;
            end
            vec = '0;
            for (int k = 0; k < 4; k++) begin
                w                     = 16'($urandom);
                sidx[s*4+k]           = 2'(perm[k]);
                sdat[s*4+k]           = w;
                vec[perm[k]*16 +: 16] = w;
            end
            exp_q.push_back(vec);
        end
        p   = 0;
        cyc = 0;
        while ((p < 400 || exp_q.size() > 0) && cyc < 5000) begin
            @(posedge clk); #1;
            rr4 = ($urandom_range(0, 3) != 0);
            if (p < 400) begin
                stb4 = ($urandom_range(0, 4) != 0);
                dat4 = {sidx[p], sdat[p]};
            end else begin
                stb4 = 1'b0;
            end
            @(negedge clk);
            if (rs4 && rr4) begin
                if (exp_q.size() == 0) check("stream_extra", 128'(1), 128'(0));
                else check("stream_res", rd4, exp_q.pop_front());
            end
            if (stb4 && rdy4) p++;
            cyc++;
        end
        check("stream_words", 128'(p), 128'(400));
        check("stream_left", 128'(exp_q.size()), 128'(0));
        @(posedge clk); #1;
        stb4 = 1'b0;
        rr4  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_idle", 128'(rs4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
